// File: rtl/minmax_track_32_pkg.sv
// minmax_pkg: shared state encoding and result reset constants for the min/max tracker
package minmax_pkg;
  typedef enum logic [1:0] {S_EMPTY, S_TRACK, S_DONE} state_e;
  localparam logic [31:0] MIN_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] MAX_RST = 32'h0;
endpackage

// File: rtl/minmax_track_32_if.sv
// minmax_track_32_if: sample stream in, framed min/max result out
interface minmax_track_32_if #(parameter int CNT_W = 16);
  logic [31:0]      data_in;
  logic             valid_in;
  logic             last_in;
  logic             ready_in;
  logic [31:0]      min_out;
  logic [31:0]      max_out;
  logic [CNT_W-1:0] min_idx;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             valid_out;
  logic             ready_out;
  modport slave (
    input  data_in, valid_in, last_in, ready_out,
    output ready_in, min_out, max_out, min_idx, max_idx, count, ovf, valid_out
  );
  modport master (
    output data_in, valid_in, last_in, ready_out,
    input  ready_in, min_out, max_out, min_idx, max_idx, count, ovf, valid_out
  );
endinterface

// File: rtl/minmax_track_32_cmp.sv
// minmax_track_32_cmp: 32-bit unsigned magnitude comparator
module minmax_track_32_cmp (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        lt_o,
  output logic        gt_o
);
  assign lt_o = a_i < b_i;
  assign gt_o = a_i > b_i;
endmodule

// File: rtl/minmax_track_32.sv
// minmax_track_32: streaming running min/max tracker with framed handshaked result
module minmax_track_32
  import minmax_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  minmax_track_32_if.slave   s
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  state_e           state_q, state_d;
  logic [31:0]      min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d, cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             lt_min, gt_max, xfer, sat;
  minmax_track_32_cmp u_cmp_min (.a_i(s.data_in), .b_i(min_q), .lt_o(lt_min), .gt_o());
  minmax_track_32_cmp u_cmp_max (.a_i(s.data_in), .b_i(max_q), .lt_o(), .gt_o(gt_max));
  assign s.ready_in  = (state_q != S_DONE) && !clr_i;
  assign s.valid_out = state_q == S_DONE;
  assign s.min_out   = min_q;
  assign s.max_out   = max_q;
  assign s.min_idx   = min_idx_q;
  assign s.max_idx   = max_idx_q;
  assign s.count     = cnt_q;
  assign s.ovf       = ovf_q;
  assign xfer = s.valid_in && s.ready_in;
  assign sat  = cnt_q == CNT_MAX;
  // Next state: clear and result accept restore reset values; a transfer seeds or updates the running extremes
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (clr_i || (state_q == S_DONE && s.ready_out)) begin
      state_d   = S_EMPTY;
      min_d     = MIN_RST;
      max_d     = MAX_RST;
      min_idx_d = '0;
      max_idx_d = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end else if (xfer) begin
      state_d = s.last_in ? S_DONE : S_TRACK;
      if (state_q == S_EMPTY) begin
        min_d     = s.data_in;
        max_d     = s.data_in;
        min_idx_d = '0;
        max_idx_d = '0;
        cnt_d     = CNT_ONE;
      end else begin
        min_d     = lt_min ? s.data_in : min_q;
        min_idx_d = lt_min ? cnt_q : min_idx_q;
        max_d     = gt_max ? s.data_in : max_q;
        max_idx_d = gt_max ? cnt_q : max_idx_q;
        cnt_d     = sat ? cnt_q : cnt_q + CNT_ONE;
        ovf_d     = ovf_q || sat;
      end
    end
  end
  // State and result registers, asynchronously reset to the empty-frame values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      min_q     <= MIN_RST;
      max_q     <= MAX_RST;
      min_idx_q <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: tb/tb_minmax_track_32.sv
// tb_minmax_track_32: directed checks of the min/max tracker at CNT_W=16 and CNT_W=3
module tb_minmax_track_32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  minmax_track_32_if #(.CNT_W(16)) b16 ();
  minmax_track_32_if #(.CNT_W(3))  b3 ();
  minmax_track_32 #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .clr_i(clr), .s(b16.slave));
  minmax_track_32 #(.CNT_W(3))  dut3  (.clk(clk), .rst_n(rst_n), .clr_i(clr), .s(b3.slave));
  localparam logic [113:0] RST16 = {32'hFFFF_FFFF, 32'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0};
  localparam logic [74:0]  RST3  = {32'hFFFF_FFFF, 32'h0, 3'h0, 3'h0, 3'h0, 1'b0, 1'b0};
  function automatic logic [113:0] r16();
    return {b16.min_out, b16.max_out, b16.min_idx, b16.max_idx, b16.count, b16.ovf, b16.valid_out};
  endfunction
  function automatic logic [74:0] r3();
    return {b3.min_out, b3.max_out, b3.min_idx, b3.max_idx, b3.count, b3.ovf, b3.valid_out};
  endfunction
  task automatic send16(input logic [31:0] d, input logic l);
    b16.data_in = d; b16.last_in = l; b16.valid_in = 1'b1;
    @(posedge clk); #1;
    b16.valid_in = 1'b0; b16.last_in = 1'b0;
  endtask
  task automatic send3(input logic [31:0] d, input logic l);
    b3.data_in = d; b3.last_in = l; b3.valid_in = 1'b1;
    @(posedge clk); #1;
    b3.valid_in = 1'b0; b3.last_in = 1'b0;
  endtask
  task automatic accept16();
    b16.ready_out = 1'b1;
    @(posedge clk); #1;
    b16.ready_out = 1'b0;
  endtask
  task automatic test_reset();
    n_cmp++;
    if (r16() !== RST16) begin n_err++; $display("FAIL reset16 got=%h exp=%h", r16(), RST16); end
    n_cmp++;
    if (r3() !== RST3) begin n_err++; $display("FAIL reset3 got=%h exp=%h", r3(), RST3); end
    n_cmp++;
    if (b16.ready_in !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", b16.ready_in); end
  endtask
  task automatic test_frame();
    send16(5, 0); send16(3, 0); send16(9, 0); send16(3, 0);
    n_cmp++;
    if (b16.valid_out !== 1'b0) begin n_err++; $display("FAIL frame_early_valid got=%b exp=0", b16.valid_out); end
    send16(9, 1);
    n_cmp++;
    if (r16() !== {32'd3, 32'd9, 16'd1, 16'd2, 16'd5, 1'b0, 1'b1})
      begin n_err++; $display("FAIL frame_result got=%h exp=%h", r16(), {32'd3, 32'd9, 16'd1, 16'd2, 16'd5, 1'b0, 1'b1}); end
    n_cmp++;
    if (b16.ready_in !== 1'b0) begin n_err++; $display("FAIL frame_ready_done got=%b exp=0", b16.ready_in); end
    accept16();
    n_cmp++;
    if (r16() !== RST16) begin n_err++; $display("FAIL frame_after_accept got=%h exp=%h", r16(), RST16); end
  endtask
  task automatic test_single();
    send16(32'h8000_0000, 1);
    n_cmp++;
    if (r16() !== {32'h8000_0000, 32'h8000_0000, 16'd0, 16'd0, 16'd1, 1'b0, 1'b1})
      begin n_err++; $display("FAIL single got=%h exp=%h", r16(), {32'h8000_0000, 32'h8000_0000, 16'd0, 16'd0, 16'd1, 1'b0, 1'b1}); end
    accept16();
  endtask
  task automatic test_extremes();
    send16(32'hFFFF_FFFF, 0); send16(32'h0, 1);
    n_cmp++;
    if (r16() !== {32'h0, 32'hFFFF_FFFF, 16'd1, 16'd0, 16'd2, 1'b0, 1'b1})
      begin n_err++; $display("FAIL extremes got=%h exp=%h", r16(), {32'h0, 32'hFFFF_FFFF, 16'd1, 16'd0, 16'd2, 1'b0, 1'b1}); end
    accept16();
  endtask
  task automatic test_back_to_back();
    logic [113:0] held;
    held = {32'd2, 32'd7, 16'd1, 16'd0, 16'd2, 1'b0, 1'b1};
    send16(7, 0); send16(2, 1);
    b16.data_in = 1; b16.last_in = 1'b0; b16.valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (b16.ready_in !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d] got=%b exp=0", i, b16.ready_in); end
      n_cmp++;
      if (r16() !== held) begin n_err++; $display("FAIL hold_stable[%0d] got=%h exp=%h", i, r16(), held); end
    end
    b16.data_in = 100; b16.last_in = 1'b1; b16.ready_out = 1'b1;
    @(posedge clk); #1;
    b16.ready_out = 1'b0;
    n_cmp++;
    if ({b16.valid_out, b16.ready_in} !== 2'b01)
      begin n_err++; $display("FAIL bubble got=%b exp=01", {b16.valid_out, b16.ready_in}); end
    @(posedge clk); #1;
    b16.valid_in = 1'b0; b16.last_in = 1'b0;
    n_cmp++;
    if (r16() !== {32'd100, 32'd100, 16'd0, 16'd0, 16'd1, 1'b0, 1'b1})
      begin n_err++; $display("FAIL second_frame got=%h exp=%h", r16(), {32'd100, 32'd100, 16'd0, 16'd0, 16'd1, 1'b0, 1'b1}); end
    accept16();
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 7; i++) send3(20 + i, 0);
    n_cmp++;
    if (r3() !== {32'd20, 32'd26, 3'd0, 3'd6, 3'd7, 1'b0, 1'b0})
      begin n_err++; $display("FAIL sat_full got=%h exp=%h", r3(), {32'd20, 32'd26, 3'd0, 3'd6, 3'd7, 1'b0, 1'b0}); end
    send3(27, 0);
    n_cmp++;
    if (r3() !== {32'd20, 32'd27, 3'd0, 3'd7, 3'd7, 1'b1, 1'b0})
      begin n_err++; $display("FAIL sat_ovf got=%h exp=%h", r3(), {32'd20, 32'd27, 3'd0, 3'd7, 3'd7, 1'b1, 1'b0}); end
    send3(5, 1);
    n_cmp++;
    if (r3() !== {32'd5, 32'd27, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1})
      begin n_err++; $display("FAIL sat_min_idx got=%h exp=%h", r3(), {32'd5, 32'd27, 3'd7, 3'd7, 3'd7, 1'b1, 1'b1}); end
    b3.ready_out = 1'b1;
    @(posedge clk); #1;
    b3.ready_out = 1'b0;
    n_cmp++;
    if (r3() !== RST3) begin n_err++; $display("FAIL sat_accept got=%h exp=%h", r3(), RST3); end
  endtask
  task automatic test_clr_rst();
    send16(10, 0); send16(20, 0);
    b16.data_in = 1; b16.valid_in = 1'b1; clr = 1'b1;
    #1;
    n_cmp++;
    if (b16.ready_in !== 1'b0) begin n_err++; $display("FAIL clr_ready got=%b exp=0", b16.ready_in); end
    @(posedge clk); #1;
    clr = 1'b0; b16.valid_in = 1'b0;
    n_cmp++;
    if (r16() !== RST16) begin n_err++; $display("FAIL clr_state got=%h exp=%h", r16(), RST16); end
    send16(4, 1);
    n_cmp++;
    if (b16.valid_out !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid got=%b exp=1", b16.valid_out); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (r16() !== RST16) begin n_err++; $display("FAIL async_rst got=%h exp=%h", r16(), RST16); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (r16() !== RST16) begin n_err++; $display("FAIL post_rst got=%h exp=%h", r16(), RST16); end
  endtask
  initial begin
    b16.valid_in = 1'b0; b16.last_in = 1'b0; b16.data_in = '0; b16.ready_out = 1'b0;
    b3.valid_in = 1'b0; b3.last_in = 1'b0; b3.data_in = '0; b3.ready_out = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_frame();
    test_single();
    test_extremes();
    test_back_to_back();
    test_saturation();
    test_clr_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
